// File: rtl/serial_adder_pkg.sv
// Shared state encoding and elaboration helpers for the serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Plain-vector aliases keep the state register usable by legacy tools.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (width % digit == 0);
    endfunction

endpackage

// File: rtl/serial_adder_unit_if.sv
// Operand/result handshake bundle between a controller and serial_adder_unit.
interface serial_adder_unit_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             acc;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, sub, acc,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, sub, acc,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_adder_unit_digit_adder.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into its top bit.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic c;
        c     = cin;
        c_msb = cin;
        s     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_adder_unit.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands consumed DIGIT bits per enabled
// clock, LSB first, through a registered carry, with start/busy/done handshake.
module serial_adder_unit
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    serial_adder_unit_if.slave  bus
);

    localparam int             N    = WIDTH / DIGIT;
    localparam int             CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
        $error("serial_adder_unit: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf_pend;

    logic [DIGIT-1:0] d_s;
    logic             d_cout;
    logic             d_cmsb;
    logic [WIDTH-1:0] digit_wide;
    logic [WIDTH-1:0] res_next;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x     (op_a[DIGIT-1:0]),
        .y     (op_b[DIGIT-1:0]),
        .cin   (carry),
        .s     (d_s),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // New digit enters from the MSB side so that after N steps the LSB digit sits at bit 0.
    always_comb begin
        digit_wide            = '0;
        digit_wide[DIGIT-1:0] = d_s;
        res_next              = (res >> DIGIT) | (digit_wide << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            ovf_pend <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_a     <= bus.acc ? bus.sum : bus.a;
                        op_b     <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res   <= res_next;
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Overflow is decided by the top bit only, so capture it on the last digit.
                        ovf_pend <= d_cout ^ d_cmsb;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.sum  <= res;
                    bus.cout <= carry;
                    bus.ovf  <= ovf_pend;
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit: bit-serial and 4-bit-digit instances side by side.
module tb_serial_adder_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena1 = 1'b1;
    logic ena4 = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_unit_if #(.WIDTH(8)) bus1 ();
    serial_adder_unit_if #(.WIDTH(8)) bus4 ();

    serial_adder_unit #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena1),
        .bus   (bus1)
    );

    serial_adder_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena4),
        .bus   (bus4)
    );

    // Launch one op on the DIGIT=1 unit; lat = edges from start edge to done rising (-1 on timeout).
    task automatic op1(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       output int lat, output int bcnt);
        bus1.a = ia; bus1.b = ib; bus1.sub = isub; bus1.acc = 1'b0; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        lat  = 0;
        bcnt = (bus1.busy === 1'b1) ? 1 : 0;
        while (bus1.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus1.busy === 1'b1) bcnt++;
        end
        if (bus1.done !== 1'b1) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic op4(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic iacc, output int lat);
        bus4.a = ia; bus4.b = ib; bus4.sub = isub; bus4.acc = iacc; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        lat = 0;
        while (bus4.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus4.done !== 1'b1) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.acc = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0; bus4.acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_dut1: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all zero",
                     bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovf);
        end
        checks++;
        if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_dut4: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all zero",
                     bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        int lat, bcnt;
        op1(8'h0F, 8'h01, 1'b0, lat, bcnt);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL add_latency: got %0d expected 8", lat); end
        checks++;
        if (bcnt !== 8) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 8", bcnt); end
        checks++;
        if ({bus1.sum, bus1.cout, bus1.ovf} !== {8'h10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_0f_01: got sum=%h cout=%b ovf=%b expected sum=10 cout=0 ovf=0",
                     bus1.sum, bus1.cout, bus1.ovf);
        end
        checks++;
        if (bus1.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got done=%b expected 0", bus1.done); end
    endtask

    task automatic test_add_carry();
        int lat, bcnt;
        op1(8'hFF, 8'h01, 1'b0, lat, bcnt);
        checks++;
        if ({bus1.sum, bus1.cout, bus1.ovf} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ff_01: got sum=%h cout=%b ovf=%b expected sum=00 cout=1 ovf=0",
                     bus1.sum, bus1.cout, bus1.ovf);
        end
        op1(8'h7F, 8'h01, 1'b0, lat, bcnt);
        checks++;
        if ({bus1.sum, bus1.cout, bus1.ovf} !== {8'h80, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_7f_01: got sum=%h cout=%b ovf=%b expected sum=80 cout=0 ovf=1",
                     bus1.sum, bus1.cout, bus1.ovf);
        end
    endtask

    task automatic test_sub();
        int lat, bcnt;
        op1(8'h05, 8'h07, 1'b1, lat, bcnt);
        checks++;
        if ({bus1.sum, bus1.cout, bus1.ovf} !== {8'hFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_05_07: got sum=%h cout=%b ovf=%b expected sum=fe cout=0 ovf=0",
                     bus1.sum, bus1.cout, bus1.ovf);
        end
        op1(8'h80, 8'h01, 1'b1, lat, bcnt);
        checks++;
        if ({bus1.sum, bus1.cout, bus1.ovf} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_80_01: got sum=%h cout=%b ovf=%b expected sum=7f cout=1 ovf=1",
                     bus1.sum, bus1.cout, bus1.ovf);
        end
    endtask

    task automatic test_digit4_acc();
        int lat;
        op4(8'h3C, 8'h55, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL d4_latency: got %0d expected 2", lat); end
        checks++;
        if ({bus4.sum, bus4.cout, bus4.ovf} !== {8'h91, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL d4_3c_55: got sum=%h cout=%b ovf=%b expected sum=91 cout=0 ovf=1",
                     bus4.sum, bus4.cout, bus4.ovf);
        end
        // a is deliberately junk: accumulate mode must take operand A from sum.
        op4(8'hAA, 8'h01, 1'b0, 1'b1, lat);
        checks++;
        if ({bus4.sum, bus4.cout, bus4.ovf} !== {8'h92, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL d4_acc: got sum=%h cout=%b ovf=%b expected sum=92 cout=0 ovf=0",
                     bus4.sum, bus4.cout, bus4.ovf);
        end
        bus4.acc = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t, t1, t2;
        logic prev;
        bus4.a = 8'h10; bus4.b = 8'h01; bus4.sub = 1'b0; bus4.acc = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        t = 0; t1 = -1; t2 = -1; prev = bus4.done;
        while (t < 30 && t2 < 0) begin
            @(posedge clk); #1;
            t++;
            if (bus4.done === 1'b1 && prev !== 1'b1) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
            prev = bus4.done;
        end
        bus4.start = 1'b0;
        checks++;
        if (t1 !== 2) begin errors++; $display("FAIL b2b_first_done: got edge %0d expected 2", t1); end
        checks++;
        if (t2 - t1 !== 4) begin errors++; $display("FAIL b2b_period: got %0d expected 4", t2 - t1); end
        @(posedge clk); #1;
        checks++;
        if (bus4.sum !== 8'h11) begin errors++; $display("FAIL b2b_sum: got %h expected 11", bus4.sum); end
        @(posedge clk); #1;
        checks++;
        if (bus4.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", bus4.busy); end
    endtask

    task automatic test_stall_ignored_start();
        int lat;
        bus1.a = 8'h12; bus1.b = 8'h34; bus1.sub = 1'b0; bus1.acc = 1'b0; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        lat = 0;
        while (bus1.done !== 1'b1 && lat < 40) begin
            ena1       = !(lat >= 2 && lat <= 4);
            bus1.start = (lat >= 1 && lat <= 6);
            bus1.a     = 8'hFF;
            bus1.b     = 8'hFF;
            @(posedge clk); #1;
            lat++;
            if (lat == 4) begin
                checks++;
                if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: got busy=%b done=%b expected busy=1 done=0", bus1.busy, bus1.done);
                end
            end
        end
        bus1.start = 1'b0;
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL stall_latency: got %0d expected 11", lat); end
        ena1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus1.done !== 1'b1) begin errors++; $display("FAIL done_stalled: got done=%b expected 1", bus1.done); end
        ena1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus1.done, bus1.sum} !== {1'b0, 8'h46}) begin
            errors++;
            $display("FAIL stall_result: got done=%b sum=%h expected done=0 sum=46", bus1.done, bus1.sum);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus1.busy, bus1.done} !== 2'b00) begin
            errors++;
            $display("FAIL no_queued_op: got busy=%b done=%b expected 0 0", bus1.busy, bus1.done);
        end
    endtask

    task automatic test_reset_midop();
        int lat, bcnt;
        bus1.a = 8'h0F; bus1.b = 8'h01; bus1.sub = 1'b0; bus1.acc = 1'b0; bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus1.busy, bus1.done, bus1.sum} !== 10'h000) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h expected 0 0 00",
                     bus1.busy, bus1.done, bus1.sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op1(8'h01, 8'h01, 1'b0, lat, bcnt);
        checks++;
        if (lat !== 8 || bus1.sum !== 8'h02) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d sum=%h expected lat=8 sum=02", lat, bus1.sum);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_digit4_acc();
        test_back_to_back();
        test_stall_ignored_start();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
